// File: rtl/calculator_pkg.sv
// Shared calculator widths: ALU operand word and memory word (two operands).
package calculator_pkg;
  localparam int DATA_W        = 32;
  localparam int MEM_WORD_SIZE = 64;
endpackage

// File: rtl/operand_unpacker.sv
// Splits each 64-bit memory word into two ALU operands, low half first.
// Optional macro OPERAND_PREFETCH_EN adds a one-word prefetch slot for a 2-cycle word rate.
module operand_unpacker
  import calculator_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [MEM_WORD_SIZE-1:0] mem_word_i,
  input  logic                     mem_valid_i,
  output logic                     mem_ready_o,
  output logic [DATA_W-1:0]        operand_o,
  output logic                     operand_valid_o,
  input  logic                     operand_ready_i,
  output logic                     loc_o,
  output logic [7:0]               word_count_o
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

  state_t                   state_reg, state_next;
  logic [MEM_WORD_SIZE-1:0] buf_reg, buf_next;
  logic [7:0]               count_reg, count_next;
  logic [DATA_W-1:0]        operand_reg, operand_next;
  logic                     loc_reg, loc_next;
  logic                     valid_reg, valid_next;
  logic                     ready_raw;
  logic                     mem_accept;
  logic                     op_hs;

`ifdef OPERAND_PREFETCH_EN
  logic [MEM_WORD_SIZE-1:0] slot_reg, slot_next;
  logic                     slot_full_reg, slot_full_next;

  assign ready_raw = (state_reg == IDLE) || !slot_full_reg;
`else
  assign ready_raw = (state_reg == IDLE);
`endif

  // Ready is forced low while reset is held, even before the first reset edge.
  assign mem_ready_o     = ready_raw && !rst_i;
  assign mem_accept      = mem_valid_i && mem_ready_o;
  assign op_hs           = valid_reg && operand_ready_i;
  assign operand_o       = operand_reg;
  assign operand_valid_o = valid_reg;
  assign loc_o           = loc_reg;
  assign word_count_o    = count_reg;

  always_comb begin
    state_next = state_reg;
    buf_next   = buf_reg;
    count_next = count_reg;
`ifdef OPERAND_PREFETCH_EN
    slot_next      = slot_reg;
    slot_full_next = slot_full_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (mem_accept) begin
          buf_next   = mem_word_i;
          state_next = LOW;
        end
      end
      LOW: begin
        if (op_hs) state_next = HIGH;
`ifdef OPERAND_PREFETCH_EN
        if (mem_accept) begin
          slot_next      = mem_word_i;
          slot_full_next = 1'b1;
        end
`endif
      end
      HIGH: begin
        if (op_hs) begin
          count_next = count_reg + 8'd1;
          state_next = IDLE;
`ifdef OPERAND_PREFETCH_EN
          if (slot_full_reg) begin
            buf_next       = slot_reg;
            slot_full_next = 1'b0;
            state_next     = LOW;
          end else if (mem_accept) begin
            // Slot is empty, so the arriving word bypasses it.
            buf_next   = mem_word_i;
            state_next = LOW;
          end
`endif
        end
`ifdef OPERAND_PREFETCH_EN
        else if (mem_accept) begin
          slot_next      = mem_word_i;
          slot_full_next = 1'b1;
        end
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_reg.
  always_comb begin
    operand_next = '0;
    loc_next     = 1'b0;
    valid_next   = 1'b0;
    case (state_next)
      LOW: begin
        operand_next = buf_next[DATA_W-1:0];
        valid_next   = 1'b1;
      end
      HIGH: begin
        operand_next = buf_next[MEM_WORD_SIZE-1:DATA_W];
        loc_next     = 1'b1;
        valid_next   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg   <= IDLE;
      buf_reg     <= '0;
      count_reg   <= '0;
      operand_reg <= '0;
      loc_reg     <= 1'b0;
      valid_reg   <= 1'b0;
`ifdef OPERAND_PREFETCH_EN
      slot_reg      <= '0;
      slot_full_reg <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      buf_reg     <= buf_next;
      count_reg   <= count_next;
      operand_reg <= operand_next;
      loc_reg     <= loc_next;
      valid_reg   <= valid_next;
`ifdef OPERAND_PREFETCH_EN
      slot_reg      <= slot_next;
      slot_full_reg <= slot_full_next;
`endif
    end
  end

endmodule
